wave_rom_scheduler: RTL

Two-channel waveform address sequencer that time-shares one single-port waveform ROM, such as the square-wave table, between two DDS channels. Each channel has its own phase accumulator, tuning word and phase offset. The block issues interleaved ROM addresses and tags each read with its channel. It then routes the returned samples to per-channel outputs with valid strobes. It sits between the register/control logic and the waveform ROM, and feeds the DAC/oscilloscope sample path.

---
 rtl/wave_rom_scheduler.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/wave_rom_scheduler.sv
// rtl/wave_rom_scheduler.sv - two-channel DDS address sequencer time-sharing one waveform ROM
// Reads alternate ch0/ch1 each RUN cycle; a tag pipeline routes returned samples to per-channel outputs.
module wave_rom_scheduler #(
  parameter int ACC_W   = 32,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 8,
  parameter int ROM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  output logic              busy,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic              cfg_ch,
  input  logic [ACC_W-1:0]  cfg_ftw,
  input  logic [ACC_W-1:0]  cfg_poff,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_rd_data,
  output logic [DATA_W-1:0] ch0_data,
  output logic [DATA_W-1:0] ch1_data,
  output logic              ch0_valid,
  output logic              ch1_valid
);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_e;

  state_e              state_q, state_d;
  logic                slot_q, slot_d;
  logic [ACC_W-1:0]    acc_q [2];
  logic [ACC_W-1:0]    acc_d [2];
  logic [ACC_W-1:0]    ftw_q [2];
  logic [ACC_W-1:0]    ftw_d [2];
  logic [ACC_W-1:0]    poff_q [2];
  logic [ACC_W-1:0]    poff_d [2];
  logic [ACC_W-1:0]    base [2];
  logic [ACC_W-1:0]    sum;
  logic                pend_q, pend_d;
  logic                pend_ch_q, pend_ch_d;
  logic [ACC_W-1:0]    pend_ftw_q, pend_ftw_d;
  logic [ACC_W-1:0]    pend_poff_q, pend_poff_d;
  logic                applied_q, applied_d;
  logic                rdy_q, rdy_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ROM_LAT:0]    tag_v_q, tag_v_d;
  logic [ROM_LAT:0]    tag_ch_q, tag_ch_d;
  logic [DATA_W-1:0]   ch0_data_q, ch0_data_d;
  logic [DATA_W-1:0]   ch1_data_q, ch1_data_d;
  logic                ch0_valid_q, ch0_valid_d;
  logic                ch1_valid_q, ch1_valid_d;
  logic                issue, issue_ch, apply;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start && !stop) state_d = S_RUN;
      S_RUN:   if (stop) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    // A read is issued on every edge that lands in RUN, including the start edge itself.
    issue    = (state_d == S_RUN);
    issue_ch = (state_q == S_RUN) ? slot_q : 1'b0;
    slot_d   = slot_q;
    addr_d   = addr_q;
    acc_d    = acc_q;
    ftw_d    = ftw_q;
    poff_d   = poff_q;
    sum      = '0;
    for (int i = 0; i < 2; i++) begin
      base[i] = (state_q == S_RUN) ? acc_q[i] : '0;
    end
    if (issue) begin
      sum    = base[issue_ch] + poff_q[issue_ch];
      addr_d = sum[ACC_W-1 -: ADDR_W];
      for (int i = 0; i < 2; i++) begin
        acc_d[i] = (issue_ch == i[0]) ? base[i] + ftw_q[i] : base[i];
      end
      slot_d = ~issue_ch;
    end

    // Pending config lands alongside its channel's read, which still used the old values.
    apply       = pend_q && ((state_q == S_IDLE) || (issue && (issue_ch == pend_ch_q)));
    pend_d      = pend_q;
    pend_ch_d   = pend_ch_q;
    pend_ftw_d  = pend_ftw_q;
    pend_poff_d = pend_poff_q;
    rdy_d       = rdy_q;
    applied_d   = apply && (state_q == S_RUN);
    if (apply) begin
      ftw_d[pend_ch_q]  = pend_ftw_q;
      poff_d[pend_ch_q] = pend_poff_q;
      pend_d            = 1'b0;
    end
    if (cfg_valid && rdy_q) begin
      pend_d      = 1'b1;
      pend_ch_d   = cfg_ch;
      pend_ftw_d  = cfg_ftw;
      pend_poff_d = cfg_poff;
      rdy_d       = 1'b0;
    end
    if ((apply && (state_q == S_IDLE)) || applied_q) rdy_d = 1'b1;

    tag_v_d     = {tag_v_q[ROM_LAT-1:0], issue};
    tag_ch_d    = {tag_ch_q[ROM_LAT-1:0], issue_ch};
    ch0_valid_d = tag_v_q[ROM_LAT] & ~tag_ch_q[ROM_LAT];
    ch1_valid_d = tag_v_q[ROM_LAT] & tag_ch_q[ROM_LAT];
    ch0_data_d  = ch0_valid_d ? rom_rd_data : ch0_data_q;
    ch1_data_d  = ch1_valid_d ? rom_rd_data : ch1_data_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      slot_q      <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        acc_q[i]  <= '0;
        ftw_q[i]  <= '0;
        poff_q[i] <= '0;
      end
      pend_q      <= 1'b0;
      pend_ch_q   <= 1'b0;
      pend_ftw_q  <= '0;
      pend_poff_q <= '0;
      applied_q   <= 1'b0;
      rdy_q       <= 1'b1;
      addr_q      <= '0;
      tag_v_q     <= '0;
      tag_ch_q    <= '0;
      ch0_data_q  <= '0;
      ch1_data_q  <= '0;
      ch0_valid_q <= 1'b0;
      ch1_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      acc_q       <= acc_d;
      ftw_q       <= ftw_d;
      poff_q      <= poff_d;
      pend_q      <= pend_d;
      pend_ch_q   <= pend_ch_d;
      pend_ftw_q  <= pend_ftw_d;
      pend_poff_q <= pend_poff_d;
      applied_q   <= applied_d;
      rdy_q       <= rdy_d;
      addr_q      <= addr_d;
      tag_v_q     <= tag_v_d;
      tag_ch_q    <= tag_ch_d;
      ch0_data_q  <= ch0_data_d;
      ch1_data_q  <= ch1_data_d;
      ch0_valid_q <= ch0_valid_d;
      ch1_valid_q <= ch1_valid_d;
    end
  end

  assign busy      = (state_q == S_RUN);
  assign cfg_ready = rdy_q;
  assign rom_addr  = addr_q;
  assign ch0_data  = ch0_data_q;
  assign ch1_data  = ch1_data_q;
  assign ch0_valid = ch0_valid_q;
  assign ch1_valid = ch1_valid_q;

endmodule
